// File: rtl/pad_cfg_ctrl_if.sv
// Serial configuration stream and status signals for pad_cfg_ctrl.
interface pad_cfg_ctrl_if;
    logic cfg_start;
    logic cfg_bit_valid;
    logic cfg_bit;
    logic cfg_end;
    logic cfg_busy;
    logic cfg_done;
    logic cfg_err;
    logic cfg_sdo;

    modport master (
        output cfg_start, cfg_bit_valid, cfg_bit, cfg_end,
        input  cfg_busy, cfg_done, cfg_err, cfg_sdo
    );

    modport slave (
        input  cfg_start, cfg_bit_valid, cfg_bit, cfg_end,
        output cfg_busy, cfg_done, cfg_err, cfg_sdo
    );
endinterface

// File: rtl/pad_cfg_ctrl.sv
// Bit-serial GPIO pad configuration loader with an atomic, length-checked commit.
// Optional readback of the previous configuration on cfg_sdo: define PAD_CFG_READBACK_EN.
module pad_cfg_ctrl #(
    parameter int unsigned NUM_BIDIR_PADS = 12,
    parameter int unsigned CFG_W          = 6,
    parameter logic [CFG_W-1:0] RST_CFG   = 6'b000101
) (
    input  logic                      clk,
    input  logic                      rst,
    pad_cfg_ctrl_if.slave             cfg,
    output logic [NUM_BIDIR_PADS-1:0] pad_oe,
    output logic [NUM_BIDIR_PADS-1:0] pad_cs,
    output logic [NUM_BIDIR_PADS-1:0] pad_sl,
    output logic [NUM_BIDIR_PADS-1:0] pad_ie,
    output logic [NUM_BIDIR_PADS-1:0] pad_pu,
    output logic [NUM_BIDIR_PADS-1:0] pad_pd
);
    localparam int unsigned TOTAL = NUM_BIDIR_PADS * CFG_W;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
    localparam logic [TOTAL-1:0] RST_ALL = {NUM_BIDIR_PADS{RST_CFG}};

    typedef enum logic [1:0] {StIdle, StShift, StCommit, StErr} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_acc;
    logic [TOTAL-1:0] shadow_q, shadow_d;
    logic [TOTAL-1:0] live_q, live_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= RST_ALL;
            live_q   <= RST_ALL;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            live_q   <= live_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        live_d   = live_q;
        err_d    = err_q;
        cnt_acc  = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cfg.cfg_start) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    err_d   = 1'b0;
`ifdef PAD_CFG_READBACK_EN
                    shadow_d = live_q;
`endif
                end
            end
            StShift: begin
                if (cfg.cfg_start) begin
                    // Restart: old shadow bits stay but are no longer counted.
                    cnt_d = '0;
                    err_d = 1'b0;
                end else if (cfg.cfg_bit_valid && (cnt_q == CNT_FULL)) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    if (cfg.cfg_bit_valid) begin
                        shadow_d = {shadow_q[TOTAL-2:0], cfg.cfg_bit};
                        cnt_acc  = cnt_q + 1'b1;
                        cnt_d    = cnt_acc;
                    end
                    // End is judged on the count including a same-cycle bit.
                    if (cfg.cfg_end) begin
                        if (cnt_acc == CNT_FULL) begin
                            state_d = StCommit;
                        end else begin
                            state_d = StErr;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            StCommit: begin
                live_d  = shadow_q;
                state_d = StIdle;
            end
            StErr: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign cfg.cfg_busy = (state_q == StShift);
    assign cfg.cfg_done = (state_q == StCommit);
    assign cfg.cfg_err  = err_q;
`ifdef PAD_CFG_READBACK_EN
    assign cfg.cfg_sdo  = (state_q == StShift) ? shadow_q[TOTAL-1] : 1'b0;
`else
    assign cfg.cfg_sdo  = 1'b0;
`endif

    // Field order within a pad slice is {OE,CS,SL,IE,PU,PD}, MSB first.
    for (genvar i = 0; i < NUM_BIDIR_PADS; i++) begin : g_pad
        assign pad_oe[i] = live_q[CFG_W*i + 5];
        assign pad_cs[i] = live_q[CFG_W*i + 4];
        assign pad_sl[i] = live_q[CFG_W*i + 3];
        assign pad_ie[i] = live_q[CFG_W*i + 2];
        assign pad_pu[i] = live_q[CFG_W*i + 1];
        assign pad_pd[i] = live_q[CFG_W*i + 0];
    end
endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Scoreboard bench for pad_cfg_ctrl with four pads (24-bit stream).
module tb_pad_cfg_ctrl;
    localparam int unsigned NP = 4;
    localparam int unsigned TOT = NP * 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NP-1:0] pad_oe, pad_cs, pad_sl, pad_ie, pad_pu, pad_pd;

    pad_cfg_ctrl_if ifc ();

    pad_cfg_ctrl #(
        .NUM_BIDIR_PADS(NP),
        .CFG_W(6),
        .RST_CFG(6'b000101)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg(ifc),
        .pad_oe(pad_oe),
        .pad_cs(pad_cs),
        .pad_sl(pad_sl),
        .pad_ie(pad_ie),
        .pad_pu(pad_pu),
        .pad_pd(pad_pd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [TOT-1:0] cfg_q[$];
    logic           sdo_q[$];
    logic [TOT-1:0] cur_live;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NP-1:0] fld(input logic [TOT-1:0] v, input int b);
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i] = v[6*i + b];
        return r;
    endfunction

    task automatic check_pads(input logic [TOT-1:0] v);
        check("pad_oe", 32'(pad_oe), 32'(fld(v, 5)));
        check("pad_cs", 32'(pad_cs), 32'(fld(v, 4)));
        check("pad_sl", 32'(pad_sl), 32'(fld(v, 3)));
        check("pad_ie", 32'(pad_ie), 32'(fld(v, 2)));
        check("pad_pu", 32'(pad_pu), 32'(fld(v, 1)));
        check("pad_pd", 32'(pad_pd), 32'(fld(v, 0)));
    endtask

    task automatic do_start();
        ifc.cfg_start = 1'b1;
        tick();
        ifc.cfg_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        if (sdo_q.size() > 0) check("sdo_readback", 32'(ifc.cfg_sdo), 32'(sdo_q.pop_front()));
        ifc.cfg_bit_valid = 1'b1;
        ifc.cfg_bit       = b;
        tick();
        ifc.cfg_bit_valid = 1'b0;
        ifc.cfg_bit       = 1'b0;
    endtask

    task automatic send_stream(input logic [TOT-1:0] s, input int n);
        for (int i = 0; i < n; i++) send_bit(s[TOT-1-i]);
    endtask

    task automatic do_end();
        ifc.cfg_end = 1'b1;
        tick();
        ifc.cfg_end = 1'b0;
    endtask

    // COMMIT is entered on the edge sampling cfg_end; pads follow one cycle later.
    task automatic expect_commit();
        logic [TOT-1:0] e;
        check("done_pulse", 32'(ifc.cfg_done), 32'd1);
        if (cfg_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            e = cur_live;
        end else begin
            e = cfg_q.pop_front();
        end
        tick();
        check("done_one_cycle", 32'(ifc.cfg_done), 32'd0);
        check("busy_after_commit", 32'(ifc.cfg_busy), 32'd0);
        check_pads(e);
        cur_live = e;
    endtask

    localparam logic [TOT-1:0] RST_ALL = {4{6'b000101}};
    localparam logic [TOT-1:0] CFG_A = {6'b100000, 6'b100100, 6'b000110, 6'b110000};

    initial begin
        logic [TOT-1:0] v;
        logic rb;
`ifdef PAD_CFG_READBACK_EN
        rb = 1'b1;
`else
        rb = 1'b0;
`endif
        ifc.cfg_start = 1'b0;
        ifc.cfg_bit_valid = 1'b0;
        ifc.cfg_bit = 1'b0;
        ifc.cfg_end = 1'b0;
        cur_live = RST_ALL;

        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(ifc.cfg_busy), 32'd0);
        check("rst_done", 32'(ifc.cfg_done), 32'd0);
        check("rst_err", 32'(ifc.cfg_err), 32'd0);
        check("rst_sdo", 32'(ifc.cfg_sdo), 32'd0);
        check_pads(RST_ALL);

        // Full load
        do_start();
        check("busy_in_shift", 32'(ifc.cfg_busy), 32'd1);
        send_stream(CFG_A, 24);
        cfg_q.push_back(CFG_A);
        do_end();
        expect_commit();
        check("full_oe", 32'(pad_oe), 32'hD);
        check("full_cs", 32'(pad_cs), 32'h1);
        check("full_ie", 32'(pad_ie), 32'h6);
        check("full_pu", 32'(pad_pu), 32'h2);

        // Short stream
        do_start();
        send_stream(24'hABCDEF, 23);
        do_end();
        check("short_err", 32'(ifc.cfg_err), 32'd1);
        check("short_no_done", 32'(ifc.cfg_done), 32'd0);
        tick();
        check("short_err_sticky", 32'(ifc.cfg_err), 32'd1);
        check("short_idle", 32'(ifc.cfg_busy), 32'd0);
        check_pads(cur_live);
        do_start();
        check("start_clears_err", 32'(ifc.cfg_err), 32'd0);

        // Overflow on the 25th bit
        send_stream(24'h123456, 24);
        check("ovf_no_err_yet", 32'(ifc.cfg_err), 32'd0);
        send_bit(1'b1);
        check("ovf_err", 32'(ifc.cfg_err), 32'd1);
        check("ovf_not_busy", 32'(ifc.cfg_busy), 32'd0);
        tick();
        check("ovf_idle_busy", 32'(ifc.cfg_busy), 32'd0);
        check("ovf_no_done", 32'(ifc.cfg_done), 32'd0);
        check_pads(cur_live);

        // End together with the 24th bit
        v = 24'h5A3C96;
        do_start();
        send_stream(v, 23);
        ifc.cfg_bit_valid = 1'b1;
        ifc.cfg_bit = v[0];
        ifc.cfg_end = 1'b1;
        cfg_q.push_back(v);
        tick();
        ifc.cfg_bit_valid = 1'b0;
        ifc.cfg_end = 1'b0;
        expect_commit();

        // Restart mid-session, entered with a start+valid that must drop the bit
        v = 24'hC3A5F0;
        ifc.cfg_start = 1'b1;
        ifc.cfg_bit_valid = 1'b1;
        ifc.cfg_bit = 1'b1;
        tick();
        ifc.cfg_start = 1'b0;
        ifc.cfg_bit_valid = 1'b0;
        send_stream(24'hFFFFFF, 10);
        do_start();
        send_stream(v, 24);
        cfg_q.push_back(v);
        do_end();
        expect_commit();

        // Readback session shifts out the previous configuration
        v = {$urandom} & 24'hFFFFFF;
        do_start();
        for (int i = 0; i < int'(TOT); i++) sdo_q.push_back(rb ? cur_live[TOT-1-i] : 1'b0);
        send_stream(v, 24);
        check("sdo_idle_low", 32'(ifc.cfg_sdo), 32'(rb ? v[TOT-1] : 1'b0));
        cfg_q.push_back(v);
        do_end();
        expect_commit();
        check("sdo_after_low", 32'(ifc.cfg_sdo), 32'd0);

        // Reset mid-session
        do_start();
        send_stream(24'h0F0F0F, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(ifc.cfg_busy), 32'd0);
        check("midrst_err", 32'(ifc.cfg_err), 32'd0);
        check_pads(RST_ALL);
        tick();
        check("midrst_no_done", 32'(ifc.cfg_done), 32'd0);
        check("sb_drained", 32'(cfg_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
